pc_unit: RTL and testbench
==========================

# pc_unit

16-bit program counter and fetch sequencer for the CPU datapath. Holds the current fetch address and selects the next one: sequential increment, branch target, jump target or hold on stall. Drives instruction memory and the IF/ID pipeline register, which is built from the 16-bit `dff` stage; `fetch_valid` feeds that register's `enable`, and `flush` requests its clear.

## Interface

Parameters:
- `n`, 16, address width in bits.
- `RESET_VECTOR`, 16'h0000, PC value loaded on reset; bit 0 must be 0.

Ports:
- `clk`  input  1  sole clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-low reset. Asserted (0) forces the reset state immediately.
- `stall`  input  1  hold PC (hazard unit).
- `branch_taken`  input  1  take `branch_target` this cycle.
- `branch_target`  input  n  branch destination address.
- `jump`  input  1  take `jump_target` this cycle.
- `jump_target`  input  n  jump destination address.
- `halt_req`  input  1  halt instruction decoded.
- `pc`  output  n  current fetch address to instruction memory.
- `pc_plus2`  output  n  `pc + 2` modulo 2^n, passed to IF/ID for link/branch math.
- `fetch_valid`  output  1  `pc` is a real fetch; enables IF/ID capture.
- `flush`  output  1  one-cycle pulse: IF/ID contents are wrong-path and must be cleared.
- `halted`  output  1  sequencer is in HALT.
- `misalign`  output  1  sticky: an odd redirect target was seen.

## Operation

- Byte-addressed, 16-bit instructions. PC advances by 2. `pc_plus2` is combinational from `pc`. Arithmetic is unsigned and wraps: 16'hFFFE + 2 = 16'h0000, with no flag.
- State machine, registered:
  - BOOT is entered on reset. `fetch_valid`=0. It goes to RUN on the next edge; `pc` holds `RESET_VECTOR`.
  - RUN is normal fetch. `fetch_valid` = ~`stall`.
  - HALT is terminal. `pc` is frozen, `fetch_valid`=0, `halted`=1. It is left only by reset.
- Next-PC priority in RUN, highest first:
  1. `jump`: the next PC is `jump_target`.
  2. `branch_taken`: the next PC is `branch_target`.
  3. `halt_req`: the PC holds and the state goes to HALT. This is ignored while `stall`=1.
  4. `stall`: the PC holds.
  5. Otherwise the next PC is `pc_plus2`.
- A redirect (jump or branch) overrides `stall` and `halt_req` in the same cycle.
- A redirect registers `flush`=1 for exactly the following cycle.
- Redirect target alignment:
  - Bit 0 of the target is forced to 0 before loading.
  - If the raw bit 0 was 1, `misalign` is set.
  - `misalign` is cleared only by reset.
- Redirect inputs are ignored in BOOT and HALT.
- Reset values:
  - `pc` = `RESET_VECTOR`.
  - `pc_plus2` = `RESET_VECTOR` + 2.
  - `fetch_valid`, `flush`, `halted` and `misalign` are all 0.
  - State = BOOT.

## Timing

- All inputs are sampled on the rising `clk` edge.
- `pc`, `flush`, `halted`, `misalign` and the state change only on that edge or on reset assertion.
- Redirect latency is 1 cycle: a target presented in cycle k appears on `pc` in cycle k+1, with `flush`=1 in cycle k+1.
- Sequential fetch throughput is one address per cycle with no bubbles.
- The first valid fetch is the cycle after BOOT: `fetch_valid`=1 at `RESET_VECTOR` in the second cycle after reset release.
- Reset asserted mid-operation, including in HALT or during a `flush` cycle:
  - All outputs return to reset values asynchronously, with no wait for `clk`.
  - On release, the state passes through BOOT again.
- Reset is released synchronously to `clk` by the system; the block does not re-synchronize it.
- `halt_req` and a redirect in the same cycle: the redirect is taken and the halt is dropped. The decoder re-issues the halt if it is still on the correct path.

## Test plan

- Reset and boot: hold `reset`=0, then release. Required response:
  - `pc`=16'h0000 with `fetch_valid`=0 for one cycle.
  - Then `pc` goes 0000, 0002, 0004 with `fetch_valid`=1.
- Redirects:
  - `jump`=1 with `jump_target`=16'h1234 in the same cycle as `branch_taken`=1 with target 16'h0100 -> next `pc`=16'h1234, `flush`=1 for one cycle, then 16'h1236.
  - `stall`=1 for 3 cycles -> `pc` holds and `fetch_valid`=0. Asserting `branch_taken` with target 16'h0040 during the stall -> next `pc`=16'h0040 and `flush`=1.
- Wrap and alignment:
  - Run from `pc`=16'hFFFC -> FFFE, then 0000, then 0002, with no flags.
  - A jump to 16'h0101 -> `pc`=16'h0100 and `misalign`=1, which stays 1 until reset.
- Halt:
  - `halt_req`=1 while `stall`=1 -> no halt.
  - `halt_req`=1 with `stall`=0 at `pc`=16'h0020 -> `halted`=1 and `pc` frozen at 16'h0020. A later `jump` is ignored.
- Async reset: assert `reset`=0 between clock edges while in HALT. Required response:
  - `halted`, `flush` and `misalign` go to 0 and `pc` goes to `RESET_VECTOR` before the next edge.
  - After release, the BOOT sequence repeats.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: 16-bit program counter and fetch sequencer.
// Holds the current fetch address and selects the next one (sequential,
// branch, jump or hold), sequences BOOT -> RUN -> HALT, and produces the
// IF/ID capture enable and the one-cycle wrong-path flush pulse.
module pc_unit #(
  parameter int unsigned       n            = 16,
  parameter logic [n-1:0]      RESET_VECTOR = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [n-1:0] branch_target,
  input  logic         jump,
  input  logic [n-1:0] jump_target,
  input  logic         halt_req,
  output logic [n-1:0] pc,
  output logic [n-1:0] pc_plus2,
  output logic         fetch_valid,
  output logic         flush,
  output logic         halted,
  output logic         misalign
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0]   state;
  logic [1:0]   state_nxt;
  logic [n-1:0] pc_nxt;
  logic         flush_nxt;
  logic         misalign_nxt;
  logic         redirect;
  logic [n-1:0] target_raw;

  // Sequential increment wraps modulo 2^n with no carry out.
  always_comb begin
    pc_plus2 = pc + n'(2);
  end

  // Jump outranks branch when both are asserted.
  always_comb begin
    redirect   = jump | branch_taken;
    target_raw = jump ? jump_target : branch_target;
  end

  // Next-state / next-PC selection; redirect beats halt and stall.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    flush_nxt    = 1'b0;
    misalign_nxt = misalign;
    case (state)
      ST_BOOT: begin
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (redirect) begin
          pc_nxt    = {target_raw[n-1:1], 1'b0};
          flush_nxt = 1'b1;
          if (target_raw[0]) begin
            misalign_nxt = 1'b1;
          end
        end else if (halt_req && !stall) begin
          state_nxt = ST_HALT;
        end else if (!stall) begin
          pc_nxt = pc_plus2;
        end
      end
      ST_HALT: begin
        state_nxt = ST_HALT;
      end
      default: begin
        state_nxt = ST_BOOT;
      end
    endcase
  end

  // Architectural state; reset is asynchronous and active-low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_BOOT;
      pc       <= RESET_VECTOR;
      flush    <= 1'b0;
      misalign <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      flush    <= flush_nxt;
      misalign <= misalign_nxt;
    end
  end

  // Status decode: capture enable only in RUN when not stalled.
  always_comb begin
    fetch_valid = (state == ST_RUN) && !stall;
    halted      = (state == ST_HALT);
  end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed stimulus with a queue-based scoreboard for pc_unit.
module tb_pc_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        jump;
  logic [15:0] jump_target;
  logic        halt_req;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        fetch_valid;
  logic        flush;
  logic        halted;
  logic        misalign;

  typedef struct {
    int          step;
    logic [15:0] pc;
    logic        fv;
    logic        fl;
    logic        h;
    logic        m;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   step_no  = 0;
  bit   done     = 0;

  pc_unit #(.n(16), .RESET_VECTOR(16'h0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .halt_req     (halt_req),
    .pc           (pc),
    .pc_plus2     (pc_plus2),
    .fetch_valid  (fetch_valid),
    .flush        (flush),
    .halted       (halted),
    .misalign     (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_exp(input logic [15:0] epc, input logic efv,
                          input logic efl, input logic eh, input logic em);
    exp_t e;
    e.step = step_no;
    e.pc   = epc;
    e.fv   = efv;
    e.fl   = efl;
    e.h    = eh;
    e.m    = em;
    exp_q.push_back(e);
    step_no++;
  endtask

  // One cycle: drive inputs at the falling edge, record the outputs
  // expected for the cycle these inputs are presented in.
  task automatic cyc(input logic rst, input logic st,
                     input logic br, input logic [15:0] bt,
                     input logic jp, input logic [15:0] jt,
                     input logic hr,
                     input logic [15:0] epc, input logic efv,
                     input logic efl, input logic eh, input logic em);
    @(negedge clk);
    reset         = rst;
    stall         = st;
    branch_taken  = br;
    branch_target = bt;
    jump          = jp;
    jump_target   = jt;
    halt_req      = hr;
    push_exp(epc, efv, efl, eh, em);
  endtask

  // Monitor: once per cycle, after the falling edge, pop and compare.
  initial begin
    exp_t        e;
    logic [15:0] exp_p2;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e      = exp_q.pop_front();
        exp_p2 = e.pc + 16'd2;
        checks++;
        if (pc !== e.pc || pc_plus2 !== exp_p2 || fetch_valid !== e.fv ||
            flush !== e.fl || halted !== e.h || misalign !== e.m) begin
          failures++;
          $display("FAIL step%0d: got pc=%h pc2=%h fv=%b fl=%b h=%b m=%b, want pc=%h pc2=%h fv=%b fl=%b h=%b m=%b",
                   e.step, pc, pc_plus2, fetch_valid, flush, halted, misalign,
                   exp_p2 == exp_p2 ? e.pc : e.pc, exp_p2, e.fv, e.fl, e.h, e.m);
        end
      end
    end
  end

  initial begin
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    jump = 1'b0; jump_target = '0; halt_req = 1'b0;

    // Held in reset
    cyc(0,0, 0,16'h0000, 0,16'h0000, 0,  16'h0000,0,0,0,0);
    cyc(0,0, 0,16'h0000, 0,16'h0000, 0,  16'h0000,0,0,0,0);
    // Release: BOOT cycle, then sequential fetch
    cyc(1,0, 0,16'h0000, 0,16'h0000, 0,  16'h0000,0,0,0,0);
    cyc(1,0, 0,16'h0000, 0,16'h0000, 0,  16'h0000,1,0,0,0);
    cyc(1,0, 0,16'h0000, 0,16'h0000, 0,  16'h0002,1,0,0,0);
    // Jump and branch together: jump wins
    cyc(1,0, 1,16'h0100, 1,16'h1234, 0,  16'h0004,1,0,0,0);
    cyc(1,0, 0,16'h0000, 0,16'h0000, 0,  16'h1234,1,1,0,0);
    // Stall three cycles, then branch during stall
    cyc(1,1, 0,16'h0000, 0,16'h0000, 0,  16'h1236,0,0,0,0);
    cyc(1,1, 0,16'h0000, 0,16'h0000, 0,  16'h1236,0,0,0,0);
    cyc(1,1, 0,16'h0000, 0,16'h0000, 0,  16'h1236,0,0,0,0);
    cyc(1,1, 1,16'h0040, 0,16'h0000, 0,  16'h1236,0,0,0,0);
    cyc(1,0, 0,16'h0000, 0,16'h0000, 0,  16'h0040,1,1,0,0);
    // Halt request while stalled is ignored
    cyc(1,1, 0,16'h0000, 0,16'h0000, 1,  16'h0042,0,0,0,0);
    cyc(1,0, 0,16'h0000, 0,16'h0000, 0,  16'h0042,1,0,0,0);
    // Wrap around the top of the address space
    cyc(1,0, 0,16'h0000, 1,16'hFFFC, 0,  16'h0044,1,0,0,0);
    cyc(1,0, 0,16'h0000, 0,16'h0000, 0,  16'hFFFC,1,1,0,0);
    cyc(1,0, 0,16'h0000, 0,16'h0000, 0,  16'hFFFE,1,0,0,0);
    cyc(1,0, 0,16'h0000, 0,16'h0000, 0,  16'h0000,1,0,0,0);
    // Odd jump target: aligned, sticky misalign
    cyc(1,0, 0,16'h0000, 1,16'h0101, 0,  16'h0002,1,0,0,0);
    cyc(1,0, 0,16'h0000, 0,16'h0000, 0,  16'h0100,1,1,0,1);
    // Jump with halt_req in same cycle: halt dropped
    cyc(1,0, 0,16'h0000, 1,16'h0020, 1,  16'h0102,1,0,0,1);
    // Halt at 0x0020, later jump ignored
    cyc(1,0, 0,16'h0000, 0,16'h0000, 1,  16'h0020,1,1,0,1);
    cyc(1,0, 0,16'h0000, 1,16'h0500, 0,  16'h0020,0,0,1,1);
    cyc(1,0, 0,16'h0000, 0,16'h0000, 0,  16'h0020,0,0,1,1);
    // Async reset between edges while halted
    @(posedge clk);
    #3;
    reset = 1'b0;
    push_exp(16'h0000, 0, 0, 0, 0);
    @(negedge clk);
    // Release: BOOT again
    cyc(1,0, 0,16'h0000, 0,16'h0000, 0,  16'h0000,0,0,0,0);
    cyc(1,0, 0,16'h0000, 0,16'h0000, 0,  16'h0000,1,0,0,0);
    cyc(1,0, 0,16'h0000, 0,16'h0000, 0,  16'h0002,1,0,0,0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      #2;
    end
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, want 0 pending", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
